// File: rtl/img_frame_player_if.sv
// Mat-stream bundle carried from the frame player to downstream mat blocks.
// The master drives every signal; the slave only observes.
interface img_frame_player_if #(
    parameter int ROWS_BITS = 10,
    parameter int COLS_BITS = 10,
    parameter int DATA_BITS = 16
);
    logic [ROWS_BITS-1:0] m_rows;
    logic [COLS_BITS-1:0] m_cols;
    logic                 m_row_first;
    logic                 m_row_last;
    logic                 m_col_first;
    logic                 m_col_last;
    logic                 m_de;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_user;
    logic                 m_valid;

    modport master (
        output m_rows, m_cols, m_row_first, m_row_last, m_col_first,
               m_col_last, m_de, m_data, m_user, m_valid
    );

    modport slave (
        input  m_rows, m_cols, m_row_first, m_row_last, m_col_first,
               m_col_last, m_de, m_data, m_user, m_valid
    );
endinterface

// File: rtl/img_frame_player.sv
// Frame-store reader: holds one frame in a dual-port RAM and replays it as a
// mat stream with line/frame blanking and a cke stall.
module img_frame_player #(
    parameter int BUF_SIZE   = 640*480,
    parameter int ADDR_BITS  = $clog2(BUF_SIZE),
    parameter int DATA_BITS  = 16,
    parameter int ROWS_BITS  = 10,
    parameter int COLS_BITS  = 10,
    parameter int BLANK_BITS = 16,
    parameter     RAM_TYPE   = "ultra"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [COLS_BITS-1:0]  param_cols,
    input  logic [ROWS_BITS-1:0]  param_rows,
    input  logic [BLANK_BITS-1:0] param_hblank,
    input  logic [BLANK_BITS-1:0] param_vblank,
    output logic                  busy,
    input  logic                  cke,
    img_frame_player_if.master    m
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    localparam int TW = 7 + ROWS_BITS + COLS_BITS;

    state_t                state_q, state_d;
    logic [COLS_BITS-1:0]  x_q, x_d, cols_q, cols_d;
    logic [ROWS_BITS-1:0]  y_q, y_d, rows_q, rows_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [BLANK_BITS-1:0] blank_q, blank_d, hblank_q, hblank_d, vblank_q, vblank_d;
    logic                  frame_done;
    logic                  dims_ok;

    logic [ADDR_BITS-1:0]  ram_addr_q;
    logic [DATA_BITS-1:0]  ram_rd_q;
    logic [DATA_BITS-1:0]  data_q;

    logic                  de0, rf0, rl0, cf0, cl0;
    logic [TW-1:0]         tim0;
    logic [TW-1:0]         tim_d [3];
    logic [TW-1:0]         tim_q [3];

    assign dims_ok = (param_cols != '0) && (param_rows != '0);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        blank_d    = blank_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        hblank_d   = hblank_q;
        vblank_d   = vblank_q;
        frame_done = 1'b0;
        case (state_q)
            ACTIVE: begin
                addr_d = (addr_q == ADDR_BITS'(BUF_SIZE - 1)) ? '0 : addr_q + 1'b1;
                x_d    = x_q + 1'b1;
                if (x_q == cols_q - 1'b1) begin
                    x_d = '0;
                    if (y_q == rows_q - 1'b1) begin
                        if (vblank_q != '0) begin
                            state_d = VBLANK;
                            blank_d = '0;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                        if (hblank_q != '0) begin
                            state_d = HBLANK;
                            blank_d = '0;
                        end
                    end
                end
            end
            HBLANK: begin
                blank_d = blank_q + 1'b1;
                if (blank_q == hblank_q - 1'b1) begin
                    blank_d = '0;
                    state_d = ACTIVE;
                end
            end
            VBLANK: begin
                blank_d = blank_q + 1'b1;
                if (blank_q == vblank_q - 1'b1) begin
                    blank_d    = '0;
                    frame_done = 1'b1;
                end
            end
            default: ;
        endcase
        // A new frame re-latches the parameters from the ports; zero size never launches.
        if ((state_q == IDLE && start) || (frame_done && continuous)) begin
            if (dims_ok) begin
                cols_d   = param_cols;
                rows_d   = param_rows;
                hblank_d = param_hblank;
                vblank_d = param_vblank;
                x_d      = '0;
                y_d      = '0;
                addr_d   = '0;
                blank_d  = '0;
                state_d  = ACTIVE;
            end else begin
                state_d  = IDLE;
            end
        end else if (frame_done) begin
            state_d = IDLE;
        end
    end

    assign de0  = (state_q == ACTIVE);
    assign rf0  = de0 && (y_q == '0);
    assign rl0  = de0 && (y_q == rows_q - 1'b1);
    assign cf0  = de0 && (x_q == '0);
    assign cl0  = de0 && (x_q == cols_q - 1'b1);
    assign tim0 = {(state_q != IDLE), de0, rf0 && cf0, rf0, rl0, cf0, cl0, rows_q, cols_q};

    // Timing travels three stages to stay aligned with the address/RAM/output data path.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign tim_d[gi] = tim0;
        end else begin : g_tail
            assign tim_d[gi] = tim_q[gi-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            blank_q    <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            hblank_q   <= '0;
            vblank_q   <= '0;
            ram_addr_q <= '0;
            data_q     <= '0;
            tim_q      <= '{default: '0};
        end else if (cke) begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            blank_q    <= blank_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            ram_addr_q <= addr_q;
            data_q     <= ram_rd_q;
            tim_q      <= tim_d;
        end
    end

    // Read-before-write on a same-address collision; writes ignore cke.
    if (RAM_TYPE == "ultra") begin : g_uram
        (* ram_style = "ultra" *) logic [DATA_BITS-1:0] mem [BUF_SIZE];
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (cke)   ram_rd_q     <= mem[ram_addr_q];
        end
    end else begin : g_bram
        (* ram_style = "block" *) logic [DATA_BITS-1:0] mem [BUF_SIZE];
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (cke)   ram_rd_q     <= mem[ram_addr_q];
        end
    end

    assign busy = (state_q != IDLE);
    assign {m.m_valid, m.m_de, m.m_user, m.m_row_first, m.m_row_last,
            m.m_col_first, m.m_col_last, m.m_rows, m.m_cols} = tim_q[2];
    assign m.m_data = data_q;
endmodule
